// File: rtl/trim_rx.sv
// trim_rx: receives an LSB-first serial trim word clocked by an asynchronous ENCLK,
// publishing each complete frame on TRIMOUT with a VALID pulse and abandoning stalled frames.
module trim_rx #(
  parameter int WIDTH   = 12,
  parameter int TIMEOUT = 60000000
) (
  input  logic             CLK50,
  input  logic             RST,
  input  logic             ENCLK,
  input  logic             DIN,
  output logic [WIDTH-1:0] TRIMOUT,
  output logic             VALID,
  output logic             BUSY,
  output logic             FRAME_ERR,
  output logic [7:0]       FRAMES
);
  localparam int BW = $clog2(WIDTH + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [BW-1:0] LAST = BW'(WIDTH - 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RECV = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  logic [1:0]       r_state;
  logic             r_enclk_s1, r_enclk_s2, r_enclk_s3;
  logic             r_din_s1, r_din_s2;
  logic [WIDTH-1:0] r_shreg;
  logic [BW-1:0]    r_bcnt;
  logic [TW-1:0]    r_tcnt;
  logic [WIDTH-1:0] r_trimout;
  logic             r_valid, r_ferr;
  logic [7:0]       r_frames;
  logic             w_fall;
  logic [WIDTH-1:0] w_shift;
  logic [1:0]       w_first;
  assign w_fall    = r_enclk_s3 & ~r_enclk_s2;
  assign w_shift   = {r_din_s2, r_shreg[WIDTH-1:1]};
  assign w_first   = (WIDTH == 1) ? DONE : RECV;
  assign TRIMOUT   = r_trimout;
  assign VALID     = r_valid;
  assign FRAME_ERR = r_ferr;
  assign FRAMES    = r_frames;
  assign BUSY      = (r_state == RECV);
  always_ff @(posedge CLK50 or posedge RST) begin
    if (RST) begin
      r_state    <= IDLE;
      r_enclk_s1 <= 1'b0;
      r_enclk_s2 <= 1'b0;
      r_enclk_s3 <= 1'b0;
      r_din_s1   <= 1'b0;
      r_din_s2   <= 1'b0;
      r_shreg    <= '0;
      r_bcnt     <= '0;
      r_tcnt     <= '0;
      r_trimout  <= '0;
      r_valid    <= 1'b0;
      r_ferr     <= 1'b0;
      r_frames   <= '0;
    end else begin
      r_enclk_s1 <= ENCLK;
      r_enclk_s2 <= r_enclk_s1;
      r_enclk_s3 <= r_enclk_s2;
      r_din_s1   <= DIN;
      r_din_s2   <= r_din_s1;
      r_valid    <= 1'b0;
      r_ferr     <= 1'b0;
      case (r_state)
        IDLE: if (w_fall) begin
          r_shreg <= w_shift;
          r_bcnt  <= BW'(1);
          r_tcnt  <= '0;
          r_state <= w_first;
        end
        RECV: if (w_fall) begin
          r_shreg <= w_shift;
          r_bcnt  <= r_bcnt + 1'b1;
          r_tcnt  <= '0;
          if (r_bcnt == LAST) r_state <= DONE;
        end else if (r_tcnt == TMAX) begin
          r_ferr  <= 1'b1;
          r_shreg <= '0;
          r_bcnt  <= '0;
          r_tcnt  <= '0;
          r_state <= IDLE;
        end else begin
          r_tcnt <= r_tcnt + 1'b1;
        end
        DONE: begin
          // TRIMOUT takes the completed word even if a new frame's first bit shifts in now
          r_trimout <= r_shreg;
          r_valid   <= 1'b1;
          r_frames  <= r_frames + 1'b1;
          r_tcnt    <= '0;
          if (w_fall) begin
            r_shreg <= w_shift;
            r_bcnt  <= BW'(1);
            r_state <= w_first;
          end else begin
            r_bcnt  <= '0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_trim_rx.sv
// tb_trim_rx: directed tests for trim_rx with TIMEOUT shortened to 1000 cycles.
`timescale 1ns/1ps
module tb_trim_rx;
  logic        CLK50 = 1'b0;
  logic        RST = 1'b1;
  logic        ENCLK = 1'b0;
  logic        DIN = 1'b0;
  logic [11:0] TRIMOUT;
  logic        VALID, BUSY, FRAME_ERR;
  logic [7:0]  FRAMES;
  int          checks = 0;
  int          fails = 0;
  int          vcnt = 0;
  int          ecnt = 0;
  logic [11:0] got_q[$];

  trim_rx #(.WIDTH(12), .TIMEOUT(1000)) dut (
    .CLK50(CLK50), .RST(RST), .ENCLK(ENCLK), .DIN(DIN),
    .TRIMOUT(TRIMOUT), .VALID(VALID), .BUSY(BUSY),
    .FRAME_ERR(FRAME_ERR), .FRAMES(FRAMES)
  );

  always #10 CLK50 = ~CLK50;

  always @(negedge CLK50) begin
    if (VALID) begin
      vcnt++;
      got_q.push_back(TRIMOUT);
    end
    if (FRAME_ERR) ecnt++;
    if (VALID || FRAME_ERR) begin
      checks++;
      if (VALID && FRAME_ERR) begin
        fails++;
        $display("FAIL valid_ferr_overlap: VALID=%b FRAME_ERR=%b, required not both high", VALID, FRAME_ERR);
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge CLK50);
  endtask

  task automatic send_bit(input logic b, input int hi, input int lo);
    ENCLK = 1'b1;
    DIN = b;
    wait_cyc(hi);
    ENCLK = 1'b0;
    wait_cyc(lo);
  endtask

  task automatic send_word(input logic [11:0] w, input int hi, input int lo);
    for (int i = 0; i < 12; i++) send_bit(w[i], hi, lo);
  endtask

  task automatic do_reset();
    RST = 1'b1;
    wait_cyc(3);
    RST = 1'b0;
    wait_cyc(2);
    got_q.delete();
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic test_reset();
    wait_cyc(3);
    checks++;
    if ({TRIMOUT, VALID, BUSY, FRAME_ERR, FRAMES} !== 23'd0) begin
      fails++;
      $display("FAIL reset_outputs: got %h, required 0", {TRIMOUT, VALID, BUSY, FRAME_ERR, FRAMES});
    end
    RST = 1'b0;
    wait_cyc(2);
  endtask

  task automatic test_single();
    int v0 = vcnt;
    send_word(12'hA5C, 25, 25);
    checks++;
    if (TRIMOUT !== 12'hA5C) begin fails++; $display("FAIL single_trimout: got %h, required a5c", TRIMOUT); end
    checks++;
    if (vcnt - v0 !== 1) begin fails++; $display("FAIL single_valid_count: got %0d, required 1", vcnt - v0); end
    checks++;
    if (FRAMES !== 8'd1) begin fails++; $display("FAIL single_frames: got %0d, required 1", FRAMES); end
    checks++;
    if (BUSY !== 1'b0) begin fails++; $display("FAIL single_busy: got %b, required 0", BUSY); end
  endtask

  task automatic test_back_to_back();
    logic [11:0] exp [3] = '{12'h001, 12'h800, 12'hFFF};
    do_reset();
    for (int i = 0; i < 3; i++) send_word(exp[i], 25, 25);
    checks++;
    if (got_q.size() !== 3) begin fails++; $display("FAIL b2b_valid_count: got %0d, required 3", got_q.size()); end
    for (int i = 0; i < 3 && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp[i]) begin fails++; $display("FAIL b2b_word%0d: got %h, required %h", i, got_q[i], exp[i]); end
    end
    checks++;
    if (FRAMES !== 8'd3) begin fails++; $display("FAIL b2b_frames: got %0d, required 3", FRAMES); end
  endtask

  task automatic test_timeout();
    int e0 = ecnt;
    int v0 = vcnt;
    logic [4:0] bits = 5'b10110;
    for (int i = 0; i < 5; i++) send_bit(bits[i], 25, 25);
    wait_cyc(965);
    checks++;
    if (BUSY !== 1'b1 || ecnt !== e0) begin
      fails++;
      $display("FAIL timeout_early: got busy=%b errs=%0d, required busy=1 errs=0", BUSY, ecnt - e0);
    end
    wait_cyc(100);
    checks++;
    if (ecnt - e0 !== 1) begin fails++; $display("FAIL timeout_ferr: got %0d pulses, required 1", ecnt - e0); end
    checks++;
    if (BUSY !== 1'b0) begin fails++; $display("FAIL timeout_busy: got %b, required 0", BUSY); end
    checks++;
    if (TRIMOUT !== 12'hFFF || vcnt !== v0 || FRAMES !== 8'd3) begin
      fails++;
      $display("FAIL timeout_hold: got trim=%h valids=%0d frames=%0d, required fff 0 3", TRIMOUT, vcnt - v0, FRAMES);
    end
    send_word(12'h123, 25, 25);
    checks++;
    if (TRIMOUT !== 12'h123 || FRAMES !== 8'd4) begin
      fails++;
      $display("FAIL timeout_recover: got trim=%h frames=%0d, required 123 4", TRIMOUT, FRAMES);
    end
  endtask

  task automatic test_coincide();
    logic [11:0] w = 12'hB6D;
    int e0, v0;
    do_reset();
    e0 = ecnt;
    v0 = vcnt;
    // falls 1001 cycles apart put the edge on the cycle where the counter reaches 1000
    for (int i = 0; i < 12; i++) send_bit(w[i], 25, (i == 5) ? 976 : 25);
    checks++;
    if (ecnt !== e0) begin fails++; $display("FAIL coincide_ferr: got %0d pulses, required 0", ecnt - e0); end
    checks++;
    if (TRIMOUT !== 12'hB6D || vcnt - v0 !== 1) begin
      fails++;
      $display("FAIL coincide_word: got trim=%h valids=%0d, required b6d 1", TRIMOUT, vcnt - v0);
    end
  endtask

  task automatic test_reset_midframe();
    logic [11:0] w = 12'h3C3;
    int e0 = ecnt;
    int v0 = vcnt;
    for (int i = 0; i < 7; i++) send_bit(w[i], 25, 25);
    RST = 1'b1;
    wait_cyc(2);
    checks++;
    if ({TRIMOUT, VALID, BUSY, FRAME_ERR, FRAMES} !== 23'd0) begin
      fails++;
      $display("FAIL midreset_outputs: got %h, required 0", {TRIMOUT, VALID, BUSY, FRAME_ERR, FRAMES});
    end
    RST = 1'b0;
    wait_cyc(1100);
    checks++;
    if (ecnt !== e0 || vcnt !== v0) begin
      fails++;
      $display("FAIL midreset_pulses: got errs=%0d valids=%0d, required 0 0", ecnt - e0, vcnt - v0);
    end
    send_word(12'h0F0, 25, 25);
    checks++;
    if (TRIMOUT !== 12'h0F0 || FRAMES !== 8'd1) begin
      fails++;
      $display("FAIL midreset_recover: got trim=%h frames=%0d, required 0f0 1", TRIMOUT, FRAMES);
    end
  endtask

  task automatic test_wrap();
    int v0;
    logic [11:0] w;
    do_reset();
    v0 = vcnt;
    for (int i = 0; i < 256; i++) begin
      w = 12'(i * 37 + 5);
      send_word(w, 3, 3);
      if (i == 254) begin
        wait_cyc(8);
        check("wrap_frames_255", {24'd0, FRAMES}, 32'd255);
      end
    end
    wait_cyc(8);
    check("wrap_frames_0", {24'd0, FRAMES}, 32'd0);
    check("wrap_valid_count", 32'(vcnt - v0), 32'd256);
    check("wrap_last_word", {20'd0, TRIMOUT}, {20'd0, 12'(255 * 37 + 5)});
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_timeout();
    test_coincide();
    test_reset_midframe();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/trim_rx.md
TRIM_RX -- requirements
Module: trim_rx

Interface
REQ-001 Parameter WIDTH, default 12, trim word length in bits.
REQ-002 Parameter TIMEOUT, default 60000000, CLK50 cycles without an ENCLK falling edge before a partial frame is abandoned.
REQ-003 CLK50  input  1  system clock, 50 MHz; all logic synchronous to its rising edge.
REQ-004 RST  input  1  reset, asynchronous, active-high.
REQ-005 ENCLK  input  1  serial bit clock from the trim generator, asynchronous to CLK50, idle low.
REQ-006 DIN  input  1  serial trim data, LSB first, changes on ENCLK rising edge.
REQ-007 TRIMOUT  output  WIDTH  last complete received trim word, held until the next complete frame.
REQ-008 VALID  output  1  one-cycle pulse when TRIMOUT is updated.
REQ-009 BUSY  output  1  high while a frame is partially received.
REQ-010 FRAME_ERR  output  1  one-cycle pulse when a partial frame is abandoned by timeout.
REQ-011 FRAMES  output  8  count of good frames received.

Function
REQ-012 ENCLK and DIN SHALL each pass through a two-flop synchronizer; ENCLK SHALL have a third register for edge detection.
REQ-013 Falling edge SHALL be detected as previous synchronized ENCLK = 1 and current = 0; rising edges SHALL be ignored.
REQ-014 On a detected falling edge, the synchronized DIN SHALL be shifted in as shreg <= {din, shreg[WIDTH-1:1]}, so the first bit received ends in bit 0.
REQ-015 Latency: a bit SHALL be in shreg 3 CLK50 cycles after the ENCLK pin falls; VALID SHALL assert 1 cycle after the final bit is shifted in.
REQ-016 FSM states: IDLE, RECV, DONE.
REQ-017 IDLE: BUSY=0; on a falling edge, shift the bit in, set bit count to 1, clear the timeout counter, and go to RECV.
REQ-018 RECV: BUSY=1; on each falling edge, shift and increment the bit count; when the count reaches WIDTH, go to DONE.
REQ-019 DONE: TRIMOUT <= shreg, VALID=1 for exactly this cycle, FRAMES increments (wraps 255->0), bit count clears, and the FSM returns to IDLE.
REQ-020 A falling edge arriving in the DONE cycle SHALL be treated as the first bit of the next frame, with no bit lost.
REQ-021 The timeout counter SHALL run only in RECV, clear on every falling edge, and saturate; it SHALL be wide enough to hold TIMEOUT.
REQ-022 If the timeout counter reaches TIMEOUT in RECV: pulse FRAME_ERR for 1 cycle, clear shreg and the bit count, go to IDLE; TRIMOUT, VALID and FRAMES are unchanged.
REQ-023 If a falling edge and timeout expiry coincide, the edge SHALL win: shift, clear the counter, no FRAME_ERR.
REQ-024 VALID and FRAME_ERR SHALL never be high in the same cycle.
REQ-025 Bits beyond WIDTH cannot accumulate, because the frame closes at exactly WIDTH bits; any extra edges start a new frame.

Reset
REQ-026 While RST is high, the following SHALL hold:
- state = IDLE;
- TRIMOUT = 0, shreg = 0;
- VALID = 0, FRAME_ERR = 0, BUSY = 0;
- FRAMES = 0;
- bit count, timeout counter and all synchronizer flops = 0.
REQ-027 RST asserted mid-frame SHALL discard the partial frame with no VALID or FRAME_ERR pulse; reception SHALL restart at bit 0 on the first falling edge after release.

Verification
REQ-028 Send 12'hA5C LSB first (12 ENCLK pulses, 1 us period) -> TRIMOUT=12'hA5C, one VALID pulse, FRAMES=1, BUSY low afterwards.
REQ-029 Send 12'h001, 12'h800, 12'hFFF back-to-back with no gap -> three VALID pulses, TRIMOUT values in order, FRAMES=3.
REQ-030 Test with TIMEOUT=1000: send 5 bits, then hold ENCLK low for 1000 cycles -> FRAME_ERR pulse, TRIMOUT keeps its previous value, BUSY=0; then send 12'h123 -> TRIMOUT=12'h123.
REQ-031 Test with TIMEOUT=1000: make a falling edge coincide with the 1000th idle cycle -> no FRAME_ERR, bit accepted, frame completes normally.
REQ-032 Assert RST after 7 bits of 12'h3C3 -> all outputs 0; then send 12'h0F0 -> TRIMOUT=12'h0F0, FRAMES=1.
REQ-033 Send 256 good frames -> FRAMES wraps to 0, VALID count = 256.
